trail_collision_detector: RTL
=============================

Name: trail_collision_detector

Overview:
- Multi-bike, frame-synchronous successor to the single-bike combinational edge check.
- Snapshots every bike's position and orientation at frame start, then watches the VGA scan's pixel address and trail-RAM read data for two probe pixels ahead of each bike.
- Adds wall (off-screen probe) detection and a hit-count threshold.
- Returns a per-bike collision vector once per frame through a valid/ack handshake to the game-state controller.

Parameters:
- NUM_BIKES, 2, number of bikes checked in parallel (1..8)
- SCREEN_W, 640, pixels per row
- SCREEN_H, 480, rows per frame
- ADDR_W, 19, pixel address width
- TRAIL_W, 4, trail RAM data width; value 0 = empty, otherwise owner id 1..NUM_BIKES
- PROBE_AHEAD, 16, pixels ahead of bike centre along heading
- PROBE_SIDE, 5, lateral offset of each probe either side of heading
- HIT_THRESHOLD, 1, probe hits per frame needed to declare collision (1..3)

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; start of visible scan
- frame_end  in  1  one-cycle pulse; end of visible scan
- pixel_valid  in  1  addr valid this cycle
- addr  in  ADDR_W  scan pixel address, addr = y*SCREEN_W + x
- trail_output  in  TRAIL_W  trail RAM data for the addr presented one cycle earlier
- bike_x  in  NUM_BIKES*10  bike centre x; bike i occupies [10i+9:10i]
- bike_y  in  NUM_BIKES*9  bike centre y
- bike_orient  in  NUM_BIKES*3  0 = up, 1 = left, 2 = down, 3 = right, 4..7 = disabled
- results_valid  out  1  collision vector valid
- collision  out  NUM_BIKES  per-bike collision, stable while results_valid
- results_ack  in  1  consumer accepts results
- overrun  out  1  sticky; a frame_start arrived while results were unacknowledged

Behaviour:
- Reset (asynchronous, resetn=0):
  - State IDLE; results_valid=0, collision=0, overrun=0.
  - Hit counters and probe registers cleared.
- Snapshot on frame_start in IDLE or SCAN. In SCAN, this restarts the frame and discards counts. Move to SCAN next cycle. For each bike, register:
  - Probe coordinates, using A=PROBE_AHEAD and S=PROBE_SIDE:
    - up: (x-S, y-A) and (x+S, y-A)
    - left: (x-A, y-S) and (x-A, y+S)
    - down: (x+S, y+A) and (x-S, y+A)
    - right: (x+A, y-S) and (x+A, y+S)
  - Signed arithmetic, one bit wider than the coordinate.
  - Off-screen: any probe with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H sets that bike's wall flag. That probe never matches a pixel.
  - On-screen probe address = py*SCREEN_W + px, truncated to ADDR_W.
  - Orientation 4..7: both probes disabled, wall flag 0.
- Alignment in SCAN: addr and pixel_valid are delayed one register stage to align with trail_output (RAM read latency 1).
- Hit rule: delayed pixel_valid=1, delayed addr equals an enabled probe address, and trail_output != 0. The bike's hit counter then increments, saturating at 3. If both probes match the same address in one cycle, count 1.
- frame_end in SCAN moves the block to REPORT. The pixel in the alignment register that cycle is still evaluated.
- REPORT:
  - collision[i] = wall[i] OR (hits[i] >= HIT_THRESHOLD), registered.
  - results_valid=1 from the first REPORT cycle; values held until results_ack=1 is sampled.
  - Next cycle after ack: results_valid=0, go to IDLE.
  - frame_start in REPORT is ignored and sets overrun. Overrun clears only on reset.
- frame_end in IDLE or REPORT: ignored. pixel_valid outside SCAN: ignored.
- Latency: frame_end to results_valid = 2 cycles.

Optional Feature:
- Macro: SELF_TRAIL_IGNORE_EN
- Defined: a hit for bike i additionally requires trail_output != i+1, so a bike's own trail is not a collision; walls and other trails still count.
- Undefined: any non-zero trail_output counts, including the bike's own id.

Test Plan:
- Setup for the scenarios below: NUM_BIKES=2, HIT_THRESHOLD=1.
- Bike0 at (100,200) up, trail RAM returns 2 only at addr 184*640+95=117855 -> collision=2'b01, results_valid 2 cycles after frame_end.
- Bike1 at (630,50) right (probe x=646) with empty trail -> collision[1]=1 from wall flag only.
- Bike0 orient=5 with trail everywhere=1 -> collision[0]=0.
- Results held with ack low, second frame_start issued -> overrun=1, collision unchanged, next frame not scanned until after ack.
- resetn low mid-SCAN after a hit -> all outputs 0 immediately. The next full frame with empty trail gives collision=0.
- Bike0 hit only by trail value 1 at its probe -> collision[0]=1 without SELF_TRAIL_IGNORE_EN, 0 with it.

Source files
------------

// File: rtl/trail_collision_detector.sv
// Frame-synchronous multi-bike collision check: snapshots two probe pixels ahead of each bike, counts trail hits during the scan, reports once per frame.
// SELF_TRAIL_IGNORE_EN: when defined, a bike's own trail id never counts as a hit. Latency frame_end->results_valid 2 cycles; results held until ack.
module trail_collision_detector #(
  parameter int NUM_BIKES     = 2,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int ADDR_W        = 19,
  parameter int TRAIL_W       = 4,
  parameter int PROBE_AHEAD   = 16,
  parameter int PROBE_SIDE    = 5,
  parameter int HIT_THRESHOLD = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_start,
  input  logic                   frame_end,
  input  logic                   pixel_valid,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [TRAIL_W-1:0]     trail_output,
  input  logic [NUM_BIKES*10-1:0] bike_x,
  input  logic [NUM_BIKES*9-1:0]  bike_y,
  input  logic [NUM_BIKES*3-1:0]  bike_orient,
  output logic                   results_valid,
  output logic [NUM_BIKES-1:0]   collision,
  input  logic                   results_ack,
  output logic                   overrun
);

  localparam int XS = 11;
  localparam int YS = 10;
  localparam logic signed [XS-1:0] AX = XS'(PROBE_AHEAD);
  localparam logic signed [XS-1:0] SX = XS'(PROBE_SIDE);
  localparam logic signed [XS-1:0] WX = XS'(SCREEN_W);
  localparam logic signed [YS-1:0] AY = YS'(PROBE_AHEAD);
  localparam logic signed [YS-1:0] SY = YS'(PROBE_SIDE);
  localparam logic signed [YS-1:0] HY = YS'(SCREEN_H);

  typedef struct packed {
    logic              en0;
    logic              en1;
    logic              wall;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
  } probe_t;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  function automatic probe_t calc_probe(input logic [9:0] x, input logic [8:0] y, input logic [2:0] o);
    logic signed [XS-1:0] bx, px0, px1;
    logic signed [YS-1:0] by, py0, py1;
    logic                 off0, off1;
    probe_t               p;
    bx  = {1'b0, x};
    by  = {1'b0, y};
    px0 = bx;
    px1 = bx;
    py0 = by;
    py1 = by;
    case (o)
      3'd0: begin px0 = bx - SX; py0 = by - AY; px1 = bx + SX; py1 = by - AY; end
      3'd1: begin px0 = bx - AX; py0 = by - SY; px1 = bx - AX; py1 = by + SY; end
      3'd2: begin px0 = bx + SX; py0 = by + AY; px1 = bx - SX; py1 = by + AY; end
      3'd3: begin px0 = bx + AX; py0 = by - SY; px1 = bx + AX; py1 = by + SY; end
      default: ;
    endcase
    off0   = px0[XS-1] | (px0 >= WX) | py0[YS-1] | (py0 >= HY);
    off1   = px1[XS-1] | (px1 >= WX) | py1[YS-1] | (py1 >= HY);
    p.en0  = ~o[2] & ~off0;
    p.en1  = ~o[2] & ~off1;
    p.wall = ~o[2] & (off0 | off1);
    p.a0   = ADDR_W'(int'(py0) * SCREEN_W + int'(px0));
    p.a1   = ADDR_W'(int'(py1) * SCREEN_W + int'(px1));
    return p;
  endfunction

  probe_t               probe_d [NUM_BIKES];
  probe_t               probe_q [NUM_BIKES];
  logic [1:0]           hits_q  [NUM_BIKES];
  logic [NUM_BIKES-1:0] hit_d;
  logic [NUM_BIKES-1:0] coll_d;
  logic [NUM_BIKES-1:0] coll_q;
  state_t               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 pv_q;
  logic                 rv_q;
  logic                 ovr_q;

  always_comb begin
    hit_d  = '0;
    coll_d = '0;
    for (int i = 0; i < NUM_BIKES; i++) begin
      probe_d[i] = calc_probe(bike_x[10*i +: 10], bike_y[9*i +: 9], bike_orient[3*i +: 3]);
      // Both probes on the same address still count as a single hit.
      hit_d[i] = pv_q && (trail_output != '0) &&
                 ((probe_q[i].en0 && (addr_q == probe_q[i].a0)) ||
                  (probe_q[i].en1 && (addr_q == probe_q[i].a1)));
`ifdef SELF_TRAIL_IGNORE_EN
      if (trail_output == TRAIL_W'(i + 1)) hit_d[i] = 1'b0;
`endif
      coll_d[i] = probe_q[i].wall || (int'(hits_q[i]) >= HIT_THRESHOLD);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pv_q    <= 1'b0;
      rv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      coll_q  <= '0;
      for (int i = 0; i < NUM_BIKES; i++) begin
        probe_q[i] <= '0;
        hits_q[i]  <= '0;
      end
    end else begin
      addr_q <= addr;
      pv_q   <= (state_q == SCAN) && pixel_valid && !frame_start;
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            for (int i = 0; i < NUM_BIKES; i++) begin
              probe_q[i] <= probe_d[i];
              hits_q[i]  <= '0;
            end
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (frame_start) begin
            for (int i = 0; i < NUM_BIKES; i++) begin
              probe_q[i] <= probe_d[i];
              hits_q[i]  <= '0;
            end
          end else begin
            for (int i = 0; i < NUM_BIKES; i++) begin
              if (hit_d[i] && (hits_q[i] != 2'd3)) hits_q[i] <= hits_q[i] + 2'd1;
            end
            if (frame_end) state_q <= REPORT;
          end
        end
        REPORT: begin
          if (frame_start) ovr_q <= 1'b1;
          if (!rv_q) begin
            rv_q   <= 1'b1;
            coll_q <= coll_d;
          end else if (results_ack) begin
            rv_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign results_valid = rv_q;
  assign collision     = coll_q;
  assign overrun       = ovr_q;

endmodule
